// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU, queued/bypassed load returns and rdtime results
// onto the register file write port and its rdtime side-port.
module wb_arbiter #(
  parameter int unsigned LDQ_DEPTH  = 2,
  parameter int unsigned MAX_STARVE = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        alu_valid,
  input  logic [4:0]                  alu_rd,
  input  logic [31:0]                 alu_result,
  output logic                        alu_stall,
  input  logic                        ld_valid,
  output logic                        ld_ready,
  input  logic [4:0]                  ld_rd,
  input  logic [31:0]                 ld_data,
  input  logic                        rdt_valid,
  input  logic [4:0]                  rdt_rd,
  input  logic [31:0]                 rdt_val,
  output logic                        rf_we,
  output logic [4:0]                  rf_waddr,
  output logic [31:0]                 rf_wdata,
  output logic                        rf_rdt_req,
  output logic [4:0]                  rf_rdt_addr,
  output logic [31:0]                 rf_rdt_data,
  output logic [$clog2(LDQ_DEPTH):0]  ldq_count
);

  localparam int unsigned PW = $clog2(LDQ_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = $clog2(MAX_STARVE + 1);

  logic [4:0]    rd_mem_q   [LDQ_DEPTH];
  logic [31:0]   data_mem_q [LDQ_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          stall_q, stall_d;

  logic alu_wr, ldq_empty, ldq_full, head_wr, ld_byp, ld_enq, rdt_req;

  assign alu_wr    = alu_valid & (alu_rd != 5'd0);
  assign ldq_empty = (count_q == CW'(0));
  assign ldq_full  = (count_q == CW'(LDQ_DEPTH));
  assign head_wr   = ~alu_wr & ~ldq_empty;
  // Bypass only when nothing is queued ahead, so loads retire in arrival order
  assign ld_byp    = ~alu_wr & ldq_empty & ld_valid & (ld_rd != 5'd0);
  // rd==0 loads still handshake but are never stored
  assign ld_enq    = ld_valid & ~ldq_full & (ld_rd != 5'd0) & ~ld_byp;
  assign rdt_req   = rdt_valid & (rdt_rd != 5'd0);

  assign ld_ready  = ~ldq_full;
  assign ldq_count = count_q;
  assign alu_stall = stall_q;

  // Main-port select and rdtime side-port, suppressed while in reset
  always_comb begin
    rf_we       = 1'b0;
    rf_waddr    = 5'd0;
    rf_wdata    = 32'd0;
    rf_rdt_req  = 1'b0;
    rf_rdt_addr = 5'd0;
    rf_rdt_data = 32'd0;
    if (!reset) begin
      rf_rdt_req  = rdt_req;
      rf_rdt_addr = rdt_rd;
      rf_rdt_data = rdt_val;
      if (alu_wr) begin
        rf_we    = 1'b1;
        rf_waddr = alu_rd;
        rf_wdata = alu_result;
      end else if (head_wr) begin
        rf_we    = 1'b1;
        rf_waddr = rd_mem_q[rd_ptr_q];
        rf_wdata = data_mem_q[rd_ptr_q];
      end else if (ld_byp) begin
        rf_we    = 1'b1;
        rf_waddr = ld_rd;
        rf_wdata = ld_data;
      end else if (rdt_req) begin
        rf_we    = 1'b1;
        rf_waddr = rdt_rd;
        rf_wdata = rdt_val;
      end
    end
  end

  // Starvation tracking: stall the ALU for one cycle after MAX_STARVE wins over a waiting load
  always_comb begin
    starve_d = starve_q;
    stall_d  = 1'b0;
    count_d  = count_q + CW'(ld_enq) - CW'(head_wr);
    if (ldq_empty || head_wr) begin
      starve_d = SW'(0);
    end else if (alu_wr) begin
      if (starve_q == SW'(MAX_STARVE - 1)) stall_d = 1'b1;
      else                                 starve_d = starve_q + SW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      stall_q  <= 1'b0;
    end else begin
      if (ld_enq)  wr_ptr_q <= wr_ptr_q + PW'(1);
      if (head_wr) rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q  <= count_d;
      starve_q <= starve_d;
      stall_q  <= stall_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ld_enq) begin
      rd_mem_q[wr_ptr_q]   <= ld_rd;
      data_mem_q[wr_ptr_q] <= ld_data;
    end
  end

endmodule
